// File: rtl/d16i_pkg.sv
// Shared types for the d16i datapath: data word and registered adder result.
package d16i_pkg;

  localparam int unsigned DATA_W = 16;

  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    word_t z;
    logic  cout;
    logic  ovf;
  } add_res_t;

endpackage

// File: rtl/full_adder_1b.sv
// One-bit full adder cell; the ripple chain in full_adder_16b is built from these.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/full_adder_16b.sv
// Ripple-carry adder with registered sum, carry-out and signed overflow (1-cycle latency).
module full_adder_16b
  import d16i_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  // The result register is typed on the shared word, so WIDTH must track DATA_W.
  if (WIDTH != DATA_W || WIDTH < 2) begin : g_width_chk
    $error("full_adder_16b: WIDTH must equal d16i_pkg::DATA_W and be >= 2");
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_1b u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  add_res_t res_d;
  add_res_t res_q;
  logic     vld_q;

  always_comb begin
    res_d      = '0;
    res_d.z    = s;
    res_d.cout = c[WIDTH];
    res_d.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        res_q <= res_d;
      end
    end
  end

  assign z         = res_q.z;
  assign cout      = res_q.cout;
  assign ovf       = res_q.ovf;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_full_adder_16b.sv
// Directed and random checks of full_adder_16b against hand values and an a+b+cin model.
module tb_full_adder_16b;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] z;
  logic        cout;
  logic        ovf;
  logic        out_valid;

  int unsigned n_chk;
  int unsigned n_pass;

  full_adder_16b #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .z         (z),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {out_valid, ovf, cout, z}
  function automatic logic [18:0] pk(input logic v, input logic o, input logic c,
                                     input logic [15:0] s);
    return {v, o, c, s};
  endfunction

  task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got {vld,ovf,cout,z}=%b_%b_%b_%h expected %b_%b_%b_%h",
               tag, got[18], got[17], got[16], got[15:0],
               exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  // Drive on the falling edge, then sample just after the next rising edge.
  task automatic step(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                      input logic vv);
    @(negedge clk);
    a        = va;
    b        = vb;
    cin      = vc;
    in_valid = vv;
    @(posedge clk);
    #1;
  endtask

  logic [18:0] obs;
  logic [16:0] sum;
  logic [18:0] exp_q;
  logic        ra_v;
  logic [15:0] ra;
  logic [15:0] rb;
  logic        rc;

  assign obs = pk(out_valid, ovf, cout, z);

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    a        = 16'hffff;
    b        = 16'hffff;
    cin      = 1'b1;
    in_valid = 1'b1;

    #1 chk("reset_t0", obs, pk(1'b0, 1'b0, 1'b0, 16'h0000));
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("reset_hold", obs, pk(1'b0, 1'b0, 1'b0, 16'h0000));
    end
    @(negedge clk);
    rst_n = 1'b1;

    step(16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("zero_add", obs, pk(1'b1, 1'b0, 1'b0, 16'h0000));
    step(16'hffff, 16'h0001, 1'b0, 1'b1);
    chk("carry_out", obs, pk(1'b1, 1'b0, 1'b1, 16'h0000));
    step(16'h000f, 16'h00f0, 1'b1, 1'b1);
    chk("carry_in", obs, pk(1'b1, 1'b0, 1'b0, 16'h0100));
    step(16'h7fff, 16'h0001, 1'b0, 1'b1);
    chk("ovf_pos", obs, pk(1'b1, 1'b1, 1'b0, 16'h8000));
    step(16'h8000, 16'h8000, 1'b0, 1'b1);
    chk("ovf_neg", obs, pk(1'b1, 1'b1, 1'b1, 16'h0000));
    step(16'hffff, 16'hffff, 1'b1, 1'b1);
    chk("ones_ones_c", obs, pk(1'b1, 1'b0, 1'b1, 16'hffff));
    step(16'h0000, 16'h0000, 1'b1, 1'b1);
    chk("zero_cin", obs, pk(1'b1, 1'b0, 1'b0, 16'h0001));

    // Three back-to-back results on three consecutive cycles.
    step(16'h1234, 16'h1111, 1'b0, 1'b1);
    chk("stream0", obs, pk(1'b1, 1'b0, 1'b0, 16'h2345));
    step(16'h4000, 16'h4000, 1'b0, 1'b1);
    chk("stream1", obs, pk(1'b1, 1'b1, 1'b0, 16'h8000));
    step(16'hfffe, 16'h0001, 1'b1, 1'b1);
    chk("stream2", obs, pk(1'b1, 1'b0, 1'b1, 16'h0000));

    step('x, 'x, 1'bx, 1'b0);
    chk("hold0", obs, pk(1'b0, 1'b0, 1'b1, 16'h0000));
    step('x, 'x, 1'bx, 1'b0);
    chk("hold1", obs, pk(1'b0, 1'b0, 1'b1, 16'h0000));

    step(16'h0003, 16'h0004, 1'b0, 1'b1);
    chk("pre_rst", obs, pk(1'b1, 1'b0, 1'b0, 16'h0007));
    @(negedge clk);
    a = 16'h7000;
    b = 16'h7000;
    #2 rst_n = 1'b0;
    #1 chk("async_rst", obs, pk(1'b0, 1'b0, 1'b0, 16'h0000));
    @(posedge clk);
    #1 chk("rst_inflight", obs, pk(1'b0, 1'b0, 1'b0, 16'h0000));
    @(negedge clk);
    rst_n = 1'b1;
    step(16'h0100, 16'h0200, 1'b1, 1'b1);
    chk("post_rst", obs, pk(1'b1, 1'b0, 1'b0, 16'h0301));

    exp_q = pk(1'b1, 1'b0, 1'b0, 16'h0301);
    for (int unsigned i = 0; i < 10000; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rc   = 1'($urandom);
      ra_v = ($urandom_range(0, 7) != 0);
      if (ra_v) begin
        sum   = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
        exp_q = pk(1'b1, (ra[15] == rb[15]) && (sum[15] != ra[15]), sum[16], sum[15:0]);
        step(ra, rb, rc, 1'b1);
      end else begin
        exp_q[18] = 1'b0;
        step(ra, rb, rc, 1'b0);
      end
      chk("random", obs, exp_q);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
